dffsnq_stim_checker: RTL
========================

Name: dffsnq_stim_checker

Overview:
- Self-checking stimulus generator and monitor for a single-bit, positive-edge D flip-flop with an asynchronous active-low set, i.e. the dffsnq cell family.
- Drives the flop's D and SETN pins from an LFSR and samples its Q output.
- Compares each sample against a cycle-accurate internal model, counts mismatches, and reports pass/fail.
- Used in silicon bring-up and gate-level regression wrappers around the cell library.

Parameters:
- CNT_W, 16: width of the run-length counter and of the CYCLES input.
- ERR_W, 8: width of the error counter; the counter saturates at all-ones.
- SEED, 16'hACE1: 16-bit LFSR reset value; must be nonzero.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RN  input  1  asynchronous active-low reset.
- START  input  1  one-cycle pulse that begins a run; sampled only in IDLE.
- CYCLES  input  CNT_W  number of stimulus vectors per run; sampled on START; 0 means no vectors.
- DUT_D  output  1  registered D drive to the flop under test.
- DUT_SETN  output  1  registered active-low set drive to the flop under test.
- DUT_Q  input  1  Q of the flop under test.
- BUSY  output  1  high in RUN and DRAIN.
- DONE  output  1  one-cycle pulse on entry to IDLE from DRAIN.
- PASS  output  1  valid when DONE is high; high when ERR_CNT equals 0.
- ERR_CNT  output  ERR_W  saturating mismatch count for the current or last run.

Behaviour:
- Reset, while RN is low, asynchronously:
  - state = IDLE; LFSR = SEED.
  - DUT_D = 0, DUT_SETN = 1, BUSY = 0, DONE = 0, PASS = 0, ERR_CNT = 0.
  - Pipeline valid bits cleared.
- Reset mid-run abandons the run with no DONE pulse.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; advances once per cycle in RUN only.
  - Vector i: d_i = lfsr[0]; s_i = 0 when lfsr[4:1] == 0, else 1 (set asserted at 1/16 rate).
- States:
  - IDLE: outputs held (DUT_SETN = 1, DUT_D unchanged). START loads the remaining count from CYCLES and clears ERR_CNT, then goes to RUN. If CYCLES == 0, go directly to DRAIN.
  - RUN: launch one vector per cycle on DUT_D/DUT_SETN and decrement the count. After the last vector, go to DRAIN with DUT_SETN = 1 and DUT_D held.
  - DRAIN: exactly 2 cycles so the final vector's compare completes, then go to IDLE and pulse DONE.
- START outside IDLE is ignored.
- Model and compare:
  - Vector i is launched at edge i and captured by the flop at edge i+1.
  - Expected value: exp_i = 1 if s_i == 0, else d_i.
  - DUT_Q is sampled and compared at edge i+2 through a 2-stage {valid, exp, mask} pipeline.
- Masking: the compare is skipped when s_i == 1 and s_{i-1} == 0. Set release coincides with a capture edge, which is a recovery race. For i = 0, s_{-1} is 1.
- Mismatch is defined as valid & !mask & (DUT_Q !== exp_i). X or Z on DUT_Q counts as a mismatch.
- ERR_CNT increments by 1 per mismatch and saturates at 2^ERR_W - 1.
- PASS is registered and updated at DRAIN exit.
- BUSY falls in the same cycle DONE rises.

Optional Feature:
- Macro: DFFSNQ_CHK_ERRINJ_EN.
- With the macro defined: adds input ERR_INJ (1 bit). When it is high in a RUN cycle, the exp of the vector launched in that cycle is inverted, forcing a mismatch unless that vector is masked.
- Without the macro: no ERR_INJ port and no inversion logic.

Test Plan:
- Reset: hold RN low for 3 cycles → DUT_SETN = 1, DUT_D = 0, ERR_CNT = 0, BUSY = 0; release, idle 5 cycles → no DONE.
- Ideal flop model attached, START with CYCLES = 1000 → BUSY high for 1002 cycles, DONE pulse, PASS = 1, ERR_CNT = 0.
- DUT_Q tied to 0, CYCLES = 64 → ERR_CNT equals the count of unmasked vectors with exp = 1 (computed from SEED), PASS = 0.
- DUT_Q tied to 1, CYCLES = 600, ERR_W = 8 → ERR_CNT saturates at 255 and never wraps.
- CYCLES = 0 → DONE after 2 cycles, PASS = 1. Also: a START pulse during RUN is ignored, and RN pulled low mid-run → immediate reset values with no DONE.
- With DFFSNQ_CHK_ERRINJ_EN defined, ideal flop, ERR_INJ pulsed on 3 unmasked vectors → ERR_CNT = 3, PASS = 0.

Source files
------------

// File: rtl/dffsnq_stim_checker.sv
// dffsnq_stim_checker: LFSR-driven stimulus generator and cycle-accurate
// checker for a positive-edge D flop with asynchronous active-low set.
// Optional feature macro: DFFSNQ_CHK_ERRINJ_EN adds the ERR_INJ input, which
// inverts the expected value of the vector launched in that cycle.
module dffsnq_stim_checker #(
  parameter int          CNT_W = 16,
  parameter int          ERR_W = 8,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic [CNT_W-1:0] CYCLES,
  input  logic             DUT_Q,
`ifdef DFFSNQ_CHK_ERRINJ_EN
  input  logic             ERR_INJ,
`endif
  output logic             DUT_D,
  output logic             DUT_SETN,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] remaining;
  logic             drain_second;
  logic [15:0]      lfsr;
  logic [15:0]      lfsr_next;
  logic             lfsr_fb;

  // two-stage compare pipeline: stage 1 holds the vector being captured,
  // stage 2 the vector whose Q is on DUT_Q at the current edge
  logic p1_valid, p1_exp, p1_mask;
  logic p2_valid, p2_exp, p2_mask;

  logic             run_start;
  logic             launch;
  logic             drain_exit;
  logic             vec_d;
  logic             vec_s;
  logic             vec_exp;
  logic             vec_mask;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  assign run_start  = (state == IDLE) && START;
  assign launch     = (state == RUN);
  assign drain_exit = (state == DRAIN) && drain_second;
  assign BUSY       = (state == RUN) || (state == DRAIN);

  // Fibonacci LFSR, taps 16,14,13,11 counted from the output bit
  assign lfsr_fb   = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign lfsr_next = {lfsr_fb, lfsr[15:1]};

  // set is asserted only when the four bits above the data bit are all zero
  assign vec_d = lfsr[0];
  assign vec_s = (lfsr[4:1] != 4'd0);

`ifdef DFFSNQ_CHK_ERRINJ_EN
  assign vec_exp = (vec_s ? vec_d : 1'b1) ^ ERR_INJ;
`else
  assign vec_exp = vec_s ? vec_d : 1'b1;
`endif

  // DUT_SETN still holds the previous vector's set (1 when idle), so a set
  // release on this capture edge is a recovery race and is not compared
  assign vec_mask = vec_s && !DUT_SETN;

  // X or Z on DUT_Q must count as a mismatch, hence the case inequality
  assign mismatch = p2_valid && !p2_mask && (DUT_Q !== p2_exp);
  assign err_next = (mismatch && (ERR_CNT != {ERR_W{1'b1}})) ?
                    ERR_CNT + ERR_W'(1) : ERR_CNT;

  // state register
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // next-state decode: IDLE -> RUN (or straight to DRAIN for zero vectors),
  // RUN until the last vector is launched, then a fixed two-cycle DRAIN
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (START) begin
          next_state = (CYCLES == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (remaining == CNT_W'(1)) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_second) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // stimulus launch, run bookkeeping, compare pipeline and result registers
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      lfsr         <= SEED;
      remaining    <= '0;
      drain_second <= 1'b0;
      DUT_D        <= 1'b0;
      DUT_SETN     <= 1'b1;
      p1_valid     <= 1'b0;
      p1_exp       <= 1'b0;
      p1_mask      <= 1'b0;
      p2_valid     <= 1'b0;
      p2_exp       <= 1'b0;
      p2_mask      <= 1'b0;
      ERR_CNT      <= '0;
      DONE         <= 1'b0;
      PASS         <= 1'b0;
    end else begin
      p1_valid     <= launch;
      p1_exp       <= vec_exp;
      p1_mask      <= vec_mask;
      p2_valid     <= p1_valid;
      p2_exp       <= p1_exp;
      p2_mask      <= p1_mask;
      drain_second <= (state == DRAIN) && !drain_second;
      DONE         <= drain_exit;

      if (launch) begin
        DUT_D     <= vec_d;
        DUT_SETN  <= vec_s;
        lfsr      <= lfsr_next;
        remaining <= remaining - CNT_W'(1);
      end else begin
        DUT_SETN <= 1'b1;
      end

      if (run_start) begin
        remaining <= CYCLES;
        ERR_CNT   <= '0;
      end else begin
        ERR_CNT <= err_next;
      end

      if (drain_exit) begin
        PASS <= (err_next == '0);
      end
    end
  end

endmodule
